// File: rtl/bank_loader.sv
// bank_loader: host-side load/dump sequencer for the Data Bank.
// Streams host words into the bank and bank words back to the host.
module bank_loader #(
  parameter int W     = 24,
  parameter int NR    = 32,
  parameter int ADDRW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [ADDRW-1:0] cmd_base,
  input  logic [ADDRW:0]   cmd_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             busy,
  output logic             done,
  output logic             bank_write,
  output logic [ADDRW-1:0] bank_dira,
  output logic [W-1:0]     bank_data,
  output logic [ADDRW-1:0] bank_dirb,
  input  logic [W-1:0]     bank_B
);

  typedef enum logic [1:0] {
    IDLE, LOAD, DUMP, DONE
  } state_t;

  localparam logic [ADDRW:0]   NR_L = (ADDRW+1)'(NR);
  localparam logic [ADDRW-1:0] LAST = ADDRW'(NR - 1);
  localparam logic [ADDRW:0]   ONE  = (ADDRW+1)'(1);

  state_t           state, state_nx;
  logic [ADDRW-1:0] addr, addr_nx, addr_inc;
  logic [ADDRW:0]   rem, rem_nx, len_clamp;
  logic             out_valid_nx;
  logic [W-1:0]     out_data_nx;
  logic             load_hs, issue, consume;

  assign addr_inc  = (addr == LAST) ? '0 : addr + ADDRW'(1);
  assign len_clamp = (cmd_len > NR_L) ? NR_L : cmd_len;

  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE) & !rst;
  assign in_ready   = (state == LOAD) & !rst;
  assign load_hs    = in_valid & in_ready;
  assign bank_write = load_hs & !rst;
  assign bank_dira  = addr;
  assign bank_dirb  = addr;
  assign bank_data  = in_data;

  // Dump: refill the output register whenever it is empty or draining.
  assign issue   = (state == DUMP) & (!out_valid | out_ready)
                 & (rem != '0);
  assign consume = (state == DUMP) & out_valid & out_ready;

  // Next-state, address walk and output register refill.
  always_comb begin
    state_nx     = state;
    addr_nx      = addr;
    rem_nx       = rem;
    out_valid_nx = out_valid;
    out_data_nx  = out_data;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          addr_nx = cmd_base;
          rem_nx  = len_clamp;
          if (len_clamp == '0) state_nx = DONE;
          else if (cmd_dir)    state_nx = DUMP;
          else                 state_nx = LOAD;
        end
      end
      LOAD: begin
        if (load_hs) begin
          addr_nx = addr_inc;
          rem_nx  = rem - ONE;
          if (rem == ONE) state_nx = DONE;
        end
      end
      DUMP: begin
        if (issue) begin
          out_data_nx  = bank_B;
          out_valid_nx = 1'b1;
          addr_nx      = addr_inc;
          rem_nx       = rem - ONE;
        end else if (consume) begin
          out_valid_nx = 1'b0;
          state_nx     = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any command at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      rem       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nx;
      addr      <= addr_nx;
      rem       <= rem_nx;
      out_valid <= out_valid_nx;
      out_data  <= out_data_nx;
    end
  end

endmodule

// File: tb/tb_bank_loader.sv
// tb_bank_loader: directed bench with a queue-based reference model.
// A bench-side bank array answers read port B and absorbs writes.
module tb_bank_loader;
  localparam int W     = 24;
  localparam int NR    = 32;
  localparam int ADDRW = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_dir = 1'b0;
  logic [ADDRW-1:0] cmd_base = '0;
  logic [ADDRW:0]   cmd_len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     out_data;
  logic             busy, done, bank_write;
  logic [ADDRW-1:0] bank_dira, bank_dirb;
  logic [W-1:0]     bank_data, bank_B;

  bank_loader #(.W(W), .NR(NR), .ADDRW(ADDRW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data),
    .busy(busy), .done(done),
    .bank_write(bank_write), .bank_dira(bank_dira),
    .bank_data(bank_data), .bank_dirb(bank_dirb),
    .bank_B(bank_B)
  );

  always #5 clk = ~clk;

  logic [W-1:0] bank_mem [NR];
  assign bank_B = bank_mem[bank_dirb];
  always @(posedge clk)
    if (bank_write) bank_mem[bank_dira] <= bank_data;

  int passed = 0;
  int total  = 0;

  logic [W-1:0]       ref_mem [NR];
  logic [ADDRW+W-1:0] wq [$];
  logic [W-1:0]       dq [$];
  logic [W-1:0]       got [$];
  logic [ADDRW+W-1:0] we;

  int cyc = 0;
  int acc_cyc = 0, done_cyc = 0, ov_cyc = -1;
  int acc_cnt = 0, done_cnt = 0, wr_cnt = 0;
  bit prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    total++;
    $display("FAIL %s", name);
  endtask

  always @(posedge clk) cyc++;

  // Compare process: every write and every consumed word vs the model.
  always @(negedge clk) begin
    if (cmd_valid && cmd_ready && !rst) begin
      acc_cyc = cyc;
      acc_cnt++;
    end
    if (done) begin
      done_cyc = cyc;
      done_cnt++;
    end
    if (out_valid && ov_cyc < 0) ov_cyc = cyc;
    if (rst) check("no_write_in_reset", bank_write, 0);
    if (bank_write) begin
      wr_cnt++;
      if (wq.size() == 0) fail("unexpected_write");
      else begin
        we = wq.pop_front();
        check("wr_addr", bank_dira, we[ADDRW+W-1:W]);
        check("wr_data", bank_data, we[W-1:0]);
      end
    end
    if (prev_stall) begin
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, prev_data);
    end
    if (out_valid && out_ready && !rst) begin
      got.push_back(out_data);
      if (dq.size() == 0) fail("unexpected_word");
      else check("dump_data", out_data, dq.pop_front());
    end
    prev_stall = out_valid && !out_ready && !rst;
    prev_data  = out_data;
  end

  task automatic check_reset_outs();
    check("rs_cmd_ready", cmd_ready, 1);
    check("rs_busy", busy, 0);
    check("rs_done", done, 0);
    check("rs_in_ready", in_ready, 0);
    check("rs_out_valid", out_valid, 0);
    check("rs_out_data", out_data, 0);
    check("rs_bank_write", bank_write, 0);
    check("rs_dira", bank_dira, 0);
    check("rs_dirb", bank_dirb, 0);
  endtask

  task automatic send_cmd(input logic dir, input logic [4:0] base,
                          input logic [5:0] len, input bit hold);
    cmd_dir   = dir;
    cmd_base  = base;
    cmd_len   = len;
    cmd_valid = 1'b1;
    @(negedge clk);
    check("cmd_ready_at_accept", cmd_ready, 1);
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  function automatic logic [4:0] wrap(input logic [4:0] b, input int i);
    return 5'((int'(b) + i) % NR);
  endfunction

  // cut: number of words accepted before rst is pulsed (large = never).
  task automatic do_load(input logic [4:0] base, input logic [5:0] len,
                         input logic [W-1:0] d0, input int cut,
                         input bit hold);
    int n, nw, k, c, w0, dn0, a0;
    bit hs, did;
    n  = (int'(len) > NR) ? NR : int'(len);
    nw = (cut < n) ? cut : n;
    for (int i = 0; i < nw; i++) begin
      wq.push_back({wrap(base, i), d0 + W'(i)});
      ref_mem[wrap(base, i)] = d0 + W'(i);
    end
    w0 = wr_cnt; dn0 = done_cnt; a0 = acc_cnt;
    send_cmd(1'b0, base, len, hold);
    in_valid = 1'b1;
    in_data  = d0;
    k = 0; c = 0; did = 1'b0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (rst) rst = 1'b0;
      if (hs) begin
        k++;
        in_data = d0 + W'(k);
      end
      if (k == cut && !did) begin
        rst = 1'b1;
        did = 1'b1;
      end
      if (++c > 300) begin
        fail("load_timeout");
        break;
      end
    end
    in_valid  = 1'b0;
    cmd_valid = 1'b0;
    check("load_writes", wr_cnt - w0, nw);
    check("load_done_cnt", done_cnt - dn0, did ? 0 : 1);
    check("load_accepts", acc_cnt - a0, 1);
    check("load_wq_empty", wq.size(), 0);
    if (did) check_reset_outs();
    @(posedge clk); #1;
  endtask

  task automatic do_dump(input logic [4:0] base, input logic [5:0] len,
                         input logic [7:0] pat, input int plen);
    int n, j, c, dn0, w0;
    bit v;
    n = (int'(len) > NR) ? NR : int'(len);
    for (int i = 0; i < n; i++) dq.push_back(ref_mem[wrap(base, i)]);
    got.delete();
    dn0 = done_cnt; w0 = wr_cnt; ov_cyc = -1;
    j = 0; c = 0;
    out_ready = pat[0];
    send_cmd(1'b1, base, len, 1'b0);
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      v = out_valid;
      @(posedge clk); #1;
      if (v) j++;
      out_ready = pat[j % plen];
      if (++c > 300) begin
        fail("dump_timeout");
        break;
      end
    end
    out_ready = 1'b0;
    check("dump_done_cnt", done_cnt - dn0, 1);
    check("dump_no_writes", wr_cnt - w0, 0);
    check("dump_words", got.size(), n);
    check("dump_dq_empty", dq.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      bank_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outs();
    @(posedge clk); #1;

    do_load(5'd0, 6'd4, 24'h000001, 99, 1'b0);
    check("t1_done_lat", done_cyc - acc_cyc, 5);

    do_load(5'd30, 6'd4, 24'h000001, 99, 1'b0);
    check("t2_ref31", ref_mem[31], 24'h2);
    check("t2_ref0", ref_mem[0], 24'h3);
    do_dump(5'd30, 6'd4, 8'hFF, 1);
    check("t2_w0", got[0], 24'h1);
    check("t2_w1", got[1], 24'h2);
    check("t2_w2", got[2], 24'h3);
    check("t2_w3", got[3], 24'h4);
    check("t2_ov_lat", ov_cyc - acc_cyc, 2);
    check("t2_done_lat", done_cyc - acc_cyc, 6);

    do_dump(5'd0, 6'd3, 8'b0001_1001, 5);
    check("t3_w0", got[0], 24'h3);
    check("t3_w1", got[1], 24'h4);
    check("t3_w2", got[2], 24'h3);
    check("t3_done_lat", done_cyc - acc_cyc, 7);

    do_load(5'd7, 6'd0, 24'h000050, 99, 1'b0);
    check("t4_len0_load_lat", done_cyc - acc_cyc, 1);
    do_dump(5'd7, 6'd0, 8'hFF, 1);
    check("t4_len0_dump_lat", done_cyc - acc_cyc, 1);
    check("t4_len0_no_valid", ov_cyc, 32'hFFFF_FFFF);

    do_load(5'd5, 6'd40, 24'h000100, 99, 1'b0);
    check("t5_clamp_lat", done_cyc - acc_cyc, 33);

    do_load(5'd10, 6'd8, 24'h000200, 2, 1'b0);
    do_dump(5'd10, 6'd3, 8'hFF, 1);
    check("t6_w0", got[0], 24'h200);
    check("t6_w1", got[1], 24'h201);
    check("t6_w2", got[2], 24'h107);

    do_load(5'd20, 6'd2, 24'h000300, 99, 1'b1);
    check("t7_done_lat", done_cyc - acc_cyc, 3);
    do_dump(5'd20, 6'd2, 8'hFF, 1);
    check("t7_w0", got[0], 24'h300);
    check("t7_w1", got[1], 24'h301);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bank_loader.md
# bank_loader

Host-side load/dump sequencer for the Kalman-filter memory registers block. It sits directly upstream of the Data Bank write port and downstream of its read port B. It streams initial matrix/state words from a valid/ready host channel into consecutive bank addresses, and streams computed results back out over a second valid/ready channel. The Data Bank is only driven while the compute core is idle.

## Interface
Parameters:
- W, 24, data word width (matches Data Bank).
- NR, 32, number of bank registers.
- ADDRW, 5, bank address width; NR ≤ 2^ADDRW.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, synchronous and active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_dir  in  1  0 = load (host→bank), 1 = dump (bank→host).
- cmd_base  in  ADDRW  first bank address.
- cmd_len  in  ADDRW+1  word count; 0 allowed; values > NR are clamped to NR.
- in_valid / in_ready  in / out  1  load data handshake.
- in_data  in  W  load word.
- out_valid / out_ready  out / in  1  dump data handshake.
- out_data  out  W  dump word (registered).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at command completion.
- bank_write  out  1  Data Bank write enable.
- bank_dira  out  ADDRW  Data Bank write address.
- bank_data  out  W  Data Bank write data (= in_data).
- bank_dirb  out  ADDRW  Data Bank read address B.
- bank_B  in  W  Data Bank read port B (asynchronous read).

## Operation
- FSM states: IDLE, LOAD, DUMP, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch addr=cmd_base and remaining=min(cmd_len, NR).
  - If remaining=0, go to DONE; otherwise go to LOAD or DUMP according to cmd_dir.
- LOAD:
  - in_ready=1.
  - bank_write = in_valid & in_ready & !rst (combinational); bank_dira=addr; bank_data=in_data.
  - Each handshake: addr advances (NR-1 wraps to 0), remaining decrements.
  - Handshake with remaining=1 goes to DONE.
  - No write occurs without a handshake.
- DUMP:
  - bank_dirb=addr.
  - When (!out_valid | out_ready) and issued < len: out_data ← bank_B, out_valid ← 1, addr advances with wrap, and the issued count increments.
  - When the last word is consumed (out_valid & out_ready, nothing left to issue): out_valid ← 0 and go to DONE.
  - bank_write=0 throughout.
- DONE: done=1 for exactly one cycle, then IDLE.
- in_ready=0 outside LOAD; out_valid is only ever high in DUMP.
- A cmd_valid seen outside IDLE is ignored; it is not queued.
- Outside LOAD, bank_dira and bank_data are don't-care, but must not toggle bank_write.

## Timing
- Reset values: state=IDLE, cmd_ready=1, busy=0, done=0, in_ready=0, out_valid=0, out_data=0, bank_write=0, bank_dira=0, bank_dirb=0, internal addr/counters=0.
- Reset mid-operation aborts immediately:
  - No bank write occurs in the reset cycle (bank_write is gated by rst).
  - Any pending out_valid word is discarded.
  - done is not pulsed.
- Load latency:
  - Command accepted at edge 0; in_ready is high from cycle 1.
  - With in_valid held high, N words are written on edges 1..N.
  - done is high in cycle N+1; cmd_ready is high in cycle N+2.
- Dump latency:
  - Command accepted at edge 0; out_valid is high from cycle 2 carrying mem[base].
  - With out_ready held high, one word per cycle (full throughput).
  - Throughput is preserved by the simultaneous consume-and-refill rule in DUMP.
  - Backpressure holds out_data stable and addr unchanged.
- Length 0: done is high in the cycle after the accept, with no bank or data-channel activity.
- Wrap: base=NR-2, len=4 touches addresses NR-2, NR-1, 0, 1.

## Test plan
- Reset, then load base=0, len=4, words 0x000001..0x000004, in_valid always high → bank_write high for 4 cycles at dira 0..3; done pulses once in cycle 5.
- Load base=30, len=4, NR=32 → writes land at 30, 31, 0, 1; then dump base=30, len=4 → out_data 1, 2, 3, 4 in order.
- Dump len=3 with out_ready toggling 1,0,0,1,1 → each word is held stable while stalled, no word is lost or duplicated, and done pulses after the third handshake.
- Command with len=0, then len=40 (clamped to 32) → the first gives done the cycle after accept with no writes; the second performs exactly 32 writes.
- Assert rst for one cycle during the 3rd word of a len=8 load → only 2 words are written (addresses base and base+1), no write in the reset cycle, no done pulse, and all outputs return to their reset values.
- cmd_valid held high during LOAD → no second command is accepted until cmd_ready returns in IDLE.
